// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one iterative multiplier between two requesters,
// with operand hold registers and a one-entry response buffer per port.
module mul_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req_signed,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    input  logic [1:0]        req_flush,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [2*XLEN-1:0] rsp_hi,
    output logic [2*XLEN-1:0] rsp_lo,
    output logic              m_invalid,
    input  logic              m_inready,
    output logic              m_flush,
    output logic [1:0]        m_signed,
    output logic [XLEN-1:0]   m_a,
    output logic [XLEN-1:0]   m_b,
    input  logic              m_outvalid,
    input  logic [XLEN-1:0]   m_hi,
    input  logic [XLEN-1:0]   m_lo
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d, rr_q, rr_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      sgn_q, sgn_d;
    logic [1:0]      rv_q, rv_d;
    logic [XLEN-1:0] hi_q [2];
    logic [XLEN-1:0] lo_q [2];
    logic [1:0]      elig;
    logic            grant, accept, own_flush, store;

    always_comb begin
        // a port with an unconsumed response is blocked so every result has a slot
        elig      = req_valid & ~req_flush & ~rv_q;
        grant     = (&elig) ? rr_q : elig[1];
        accept    = state_q == IDLE && |elig;
        own_flush = req_flush[owner_q];
        store     = state_q == BUSY && m_outvalid && !own_flush;
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        rv_d      = rv_q & ~rsp_ready;
        req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
        m_invalid = 1'b0;
        m_flush   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = ISSUE;
                owner_d = grant;
                rr_d    = ~grant;
                a_d     = grant ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
                b_d     = grant ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
                sgn_d   = grant ? req_signed[3:2] : req_signed[1:0];
            end
            ISSUE: begin
                m_invalid = !own_flush;
                state_d   = own_flush ? IDLE : (m_inready ? BUSY : ISSUE);
            end
            BUSY: begin
                // a flush coinciding with outvalid wins and needs no m_flush
                m_flush = own_flush && !m_outvalid;
                state_d = (own_flush || m_outvalid) ? IDLE : BUSY;
                if (store) rv_d[owner_q] = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= '0;
            rv_q    <= '0;
            hi_q    <= '{default: '0};
            lo_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rv_q    <= rv_d;
            if (store) begin
                hi_q[owner_q] <= m_hi;
                lo_q[owner_q] <= m_lo;
            end
        end
    end

    assign rsp_valid = rv_q;
    assign rsp_hi    = {hi_q[1], hi_q[0]};
    assign rsp_lo    = {lo_q[1], lo_q[0]};
    assign m_a       = a_q;
    assign m_b       = b_q;
    assign m_signed  = sgn_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed checks of mul_arbiter against a behavioural iterative multiplier.
module tb_mul_arbiter;
    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, req_flush, rsp_valid, rsp_ready, m_signed;
    logic [3:0]  req_signed;
    logic [63:0] req_a, req_b, rsp_hi, rsp_lo;
    logic        m_invalid, m_inready, m_flush, m_outvalid;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    mul_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_a(req_a), .req_b(req_b), .req_flush(req_flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
        .m_invalid(m_invalid), .m_inready(m_inready), .m_flush(m_flush),
        .m_signed(m_signed), .m_a(m_a), .m_b(m_b),
        .m_outvalid(m_outvalid), .m_hi(m_hi), .m_lo(m_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier stand-in: mlat+1 busy cycles, inready low for 2 cycles after a flush
    logic        mbusy;
    int          mcnt, mcool, mlat;
    logic [31:0] ma_q, mb_q;
    logic [1:0]  ms_q;
    logic [65:0] ea, eb, prod;

    assign m_inready  = !mbusy && mcool == 0;
    assign m_outvalid = mbusy && mcnt == 0;
    always_comb begin
        ea   = ms_q[1] ? {{34{ma_q[31]}}, ma_q} : {34'b0, ma_q};
        eb   = ms_q[0] ? {{34{mb_q[31]}}, mb_q} : {34'b0, mb_q};
        prod = ea * eb;
    end
    assign m_hi = prod[63:32];
    assign m_lo = prod[31:0];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
            mcool <= 0;
        end else if (m_flush) begin
            mbusy <= 1'b0;
            mcool <= 2;
        end else begin
            if (mcool > 0) mcool <= mcool - 1;
            if (!mbusy && mcool == 0 && m_invalid) begin
                mbusy <= 1'b1;
                mcnt  <= mlat;
                ma_q  <= m_a;
                mb_q  <= m_b;
                ms_q  <= m_signed;
            end else if (mbusy) begin
                if (mcnt == 0) mbusy <= 1'b0;
                else mcnt <= mcnt - 1;
            end
        end
    end

    int          checks = 0, errors = 0;
    int          both_rdy = 0, nflush = 0, rsp1_cnt = 0, stalls = 0;
    int          hs [2] = '{0, 0};
    logic [63:0] last_rsp [2];
    logic        grants [$];

    always @(negedge clk) begin
        #2;
        if (rst) begin
            if (req_ready == 2'b11) both_rdy++;
            if (req_ready != 2'b00) grants.push_back(req_ready[1]);
            if (m_flush) nflush++;
            if (rsp_valid[1]) rsp1_cnt++;
            if (m_invalid && !m_inready) stalls++;
            for (int p = 0; p < 2; p++)
                if (rsp_valid[p] && rsp_ready[p]) begin
                    hs[p]++;
                    last_rsp[p] = {rsp_hi[p*32 +: 32], rsp_lo[p*32 +: 32]};
                end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [1:0] sg);
        req_a[p*32 +: 32]   = a;
        req_b[p*32 +: 32]   = b;
        req_signed[2*p +: 2] = sg;
    endtask

    task automatic accept(input int p, input string tag, output int n);
        @(negedge clk);
        req_valid[p] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[p] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_acc"}, 64'(n < 50), 64'd1);
        @(negedge clk);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_rsp(input int p, input logic [63:0] exp, input string tag);
        int n = 0;
        #1;
        while (!rsp_valid[p] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_prod"}, {rsp_hi[p*32 +: 32], rsp_lo[p*32 +: 32]}, exp);
    endtask

    task automatic consume(input int p, input string tag);
        rsp_ready[p] = 1'b1;
        @(negedge clk);
        rsp_ready[p] = 1'b0;
        #1;
        chk({tag, "_clr"}, 64'(rsp_valid[p]), 64'd0);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        #1;
        while (!(m_invalid && m_inready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_issue"}, 64'(n < 50), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, g0, h0, f0, r0, s0;
        rst = 1'b0; req_valid = '0; req_flush = '0; rsp_ready = '0;
        req_signed = '0; req_a = '0; req_b = '0; mlat = 3;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_minv", 64'({m_invalid, m_flush}), 64'd0);
        chk("rst_mops", {m_a, m_b} | 64'(m_signed), 64'd0);
        chk("rst_rsp", rsp_hi | rsp_lo, 64'd0);
        rst = 1'b1;

        // contention: rr starts at 0, so grants go 0,1,0,1
        @(negedge clk);
        set_op(0, 32'd3, 32'd5, 2'b00);
        set_op(1, 32'd7, 32'd9, 2'b00);
        g0 = grants.size(); h0 = hs[0] + hs[1];
        rsp_ready = 2'b11; req_valid = 2'b11;
        n = 0;
        while (grants.size() - g0 < 4 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        req_valid = 2'b00;
        n = 0;
        while (hs[0] + hs[1] - h0 < 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("cont_done", 64'(n < 200), 64'd1);
        rsp_ready = 2'b00;
        chk("cont_g0", 64'(grants[g0]), 64'd0);
        chk("cont_g1", 64'(grants[g0+1]), 64'd1);
        chk("cont_g2", 64'(grants[g0+2]), 64'd0);
        chk("cont_g3", 64'(grants[g0+3]), 64'd1);
        chk("cont_p0", last_rsp[0], 64'd15);
        chk("cont_p1", last_rsp[1], 64'd63);
        chk("cont_both", 64'(both_rdy), 64'd0);

        // single ops on port 0: -1*2 signed, 0xFFFFFFFF*2 unsigned
        r0 = rsp1_cnt;
        set_op(0, 32'hFFFF_FFFF, 32'd2, 2'b11);
        accept(0, "s_sgn", n);
        wait_rsp(0, 64'hFFFF_FFFF_FFFF_FFFE, "s_sgn");
        consume(0, "s_sgn");
        set_op(0, 32'hFFFF_FFFF, 32'd2, 2'b00);
        accept(0, "s_uns", n);
        wait_rsp(0, 64'h0000_0001_FFFF_FFFE, "s_uns");
        consume(0, "s_uns");
        chk("s_no_p1", 64'(rsp1_cnt - r0), 64'd0);

        // flush of port 1 three cycles into BUSY, port 0 waits out the inready gap
        mlat = 10;
        set_op(1, 32'd5, 32'd6, 2'b00);
        accept(1, "f", n);
        wait_busy("f");
        repeat (2) @(negedge clk);
        f0 = nflush; r0 = rsp1_cnt; s0 = stalls;
        req_flush[1] = 1'b1;
        #1;
        chk("f_mflush", 64'(m_flush), 64'd1);
        @(negedge clk);
        req_flush[1] = 1'b0;
        mlat = 3;
        set_op(0, 32'd11, 32'd13, 2'b00);
        req_valid[0] = 1'b1;
        #1;
        chk("f_mflush_off", 64'(m_flush), 64'd0);
        chk("f_p0_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(0, 64'd143, "f_p0");
        consume(0, "f_p0");
        chk("f_nflush", 64'(nflush - f0), 64'd1);
        chk("f_no_p1", 64'(rsp1_cnt - r0), 64'd0);
        chk("f_stall", 64'(stalls - s0 > 0), 64'd1);

        // owner flush coinciding with m_outvalid
        set_op(1, 32'd3, 32'd3, 2'b00);
        accept(1, "c", n);
        #1;
        n = 0;
        while (!m_outvalid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("c_outv", 64'(m_outvalid), 64'd1);
        req_flush[1] = 1'b1;
        #1;
        chk("c_mflush", 64'(m_flush), 64'd0);
        @(negedge clk);
        req_flush[1] = 1'b0;
        set_op(1, 32'h0001_0000, 32'h0001_0000, 2'b00);
        req_valid[1] = 1'b1;
        #1;
        chk("c_idle", 64'(req_ready), 64'd2);
        chk("c_dropped", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(1, 64'h0000_0001_0000_0000, "c_next");
        consume(1, "c_next");

        // non-owner flush during BUSY
        set_op(0, 32'd100, 32'd200, 2'b00);
        accept(0, "nof", n);
        wait_busy("nof");
        req_flush[1] = 1'b1;
        #1;
        chk("nof_mflush", 64'(m_flush), 64'd0);
        @(negedge clk);
        req_flush[1] = 1'b0;
        wait_rsp(0, 64'd20000, "nof");
        consume(0, "nof");

        // response backpressure on port 0
        set_op(0, 32'd2, 32'd3, 2'b00);
        accept(0, "bp", n);
        wait_rsp(0, 64'd6, "bp");
        set_op(0, 32'd4, 32'd5, 2'b00);
        req_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("bp_rdy", 64'(req_ready), 64'd0);
            chk("bp_inv", 64'(m_invalid), 64'd0);
            chk("bp_hold", {rsp_hi[31:0], rsp_lo[31:0]}, 64'd6);
        end
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_rdy_hs", 64'(req_ready), 64'd0);
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        #1;
        chk("bp_rspv", 64'(rsp_valid), 64'd0);
        chk("bp_acc", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp(0, 64'd20, "bp2");
        consume(0, "bp2");

        // reset in the middle of BUSY
        mlat = 10;
        set_op(1, 32'd6, 32'd7, 2'b00);
        accept(1, "r", n);
        wait_busy("r");
        rst = 1'b0;
        #1;
        chk("r_ctl", 64'({req_ready, rsp_valid, m_invalid, m_flush}), 64'd0);
        chk("r_mops", {m_a, m_b} | 64'(m_signed), 64'd0);
        chk("r_rsp", rsp_hi | rsp_lo, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mlat = 3;
        r0 = rsp1_cnt;
        repeat (15) @(negedge clk);
        chk("r_stale", 64'(rsp1_cnt - r0), 64'd0);
        accept(1, "r2", n);
        wait_rsp(1, 64'd42, "r2");
        consume(1, "r2");
        chk("end_both", 64'(both_rdy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Two-port arbiter and sequencer that shares the single iterative multiplier (`top`) between two requesters, e.g. two issue slots. It accepts requests with valid/ready handshakes and picks between them round-robin. It holds the winner's operands stable for the whole multiply, drives the multiplier's `invalid`/`flush` handshake, and returns the 2·XLEN-bit product to the owning port through a one-entry response buffer per port.

## Interface
- XLEN, 32, operand width; must match the multiplier instance.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-port request valid.
- req_ready  out  2  per-port request accept.
- req_signed  in  4  per port [2i+1:2i]; bit1 means multiplicand signed, bit0 means multiplier signed.
- req_a, req_b  in  2·XLEN  per-port operands, port i in slice [i·XLEN +: XLEN].
- req_flush  in  2  per-port kill of that port's in-flight operation.
- rsp_valid  out  2  per-port result valid.
- rsp_ready  in  2  per-port result accept.
- rsp_hi, rsp_lo  out  2·XLEN  per-port product halves, same slicing as the operands.
- m_invalid  out  1  to multiplier `invalid`.
- m_inready  in  1  from multiplier `inready`.
- m_flush  out  1  to multiplier `flush`.
- m_signed  out  2  to multiplier `mul_signed`.
- m_a, m_b  out  XLEN  to multiplier `multiplicand` / `multiplier`.
- m_outvalid  in  1  from multiplier `outvalid`.
- m_hi, m_lo  in  XLEN  from multiplier `result_hi` / `result_lo`.

## Operation
- State machine has three states: IDLE, ISSUE, BUSY. Registers: `owner` (1 bit), round-robin pointer `rr` (1 bit), operand/sign hold registers, and per port a response buffer (valid, hi, lo).
- **Eligibility.** Port i is eligible when req_valid[i] && !req_flush[i] && !rsp_valid[i].
  - A port whose response is still unconsumed is blocked, so every issued result always has a landing slot.
- **Grant.** If exactly one port is eligible, it wins. If both are eligible, port `rr` wins.
  - req_ready[i] = (state==IDLE) && grant==i; at most one bit is ever set.
- **IDLE.** On accept, capture the winner's operands and sign into the hold registers, set owner=i, set rr=~i, and go to ISSUE.
- **ISSUE.**
  - m_invalid=1 while m_inready is low and while m_inready is high. The transfer completes in the cycle m_inready=1, then go to BUSY.
  - If req_flush[owner] is set while still in ISSUE, drop the operation, deassert m_invalid and go to IDLE. No m_flush is sent.
- **BUSY.**
  - On m_outvalid, write {m_hi, m_lo} to the owner's buffer, set rsp_valid[owner]=1 and go to IDLE.
  - On req_flush[owner] without m_outvalid, drive m_flush=1 for exactly that cycle, discard the operation and go to IDLE.
  - If m_outvalid and req_flush[owner] coincide, the flush wins: the result is discarded and m_flush stays 0.
- req_flush on the non-owner port never affects the in-flight operation. It only suppresses that port's eligibility in that cycle.
- Flush never clears a response already sitting in a buffer.
- rsp_valid[i] clears when rsp_valid[i] && rsp_ready[i]. A buffer is written only when empty, so set and clear never coincide.
- m_a, m_b and m_signed always come from the hold registers. They stay stable from ISSUE entry until the return to IDLE.

## Timing
- **Reset values.** State=IDLE, owner=0, rr=0 (port 0 favoured first). All outputs are 0: req_ready, rsp_valid, rsp_hi/lo, m_invalid, m_flush, m_signed, m_a, m_b.
- **Reset mid-operation.** The abandoned result never appears. The multiplier shares the same rst, so it returns to idle as well.
- **Latency.**
  - Accept at cycle T gives m_invalid=1 at T+1; if m_inready=1 then, BUSY at T+2.
  - m_outvalid at cycle U gives rsp_valid=1 at U+1.
  - Back-to-back: the next accept can occur at U+1, the ISSUE for it at U+2, and it stalls until the multiplier reports inready.
- **After a flush in BUSY** (multiplier goes FLUSH then IDLE), m_inready stays low for 2 cycles. The next ISSUE simply holds m_invalid until m_inready rises.
- m_flush is a registered-free combinational decode of (state==BUSY && req_flush[owner] && !m_outvalid). It is high for one cycle only, because state leaves BUSY on the same edge.
- Product width: the full 2·XLEN result. Signed/unsigned handling is performed entirely by the multiplier; the arbiter passes req_signed through unchanged.

## Test plan
- **Single op, port 0.**
  - Stimulus: a=0xFFFFFFFF, b=2, signed=2'b11.
  - Required: rsp_valid[0], hi=0xFFFFFFFF, lo=0xFFFFFFFE; rsp_valid[1] never set.
  - Repeat with signed=2'b00: hi=0x00000001, lo=0xFFFFFFFE.
- **Contention.**
  - Stimulus: both ports valid continuously, responses consumed at once.
  - Required: grants alternate 0,1,0,1; each port gets its own product (port0 3×5=15, port1 7×9=63); req_ready never has both bits set.
- **Flush in BUSY.**
  - Stimulus: port 1 op accepted, req_flush[1] pulsed 3 cycles into BUSY.
  - Required: m_flush high exactly 1 cycle; no rsp_valid[1]; port 0's next request is issued once m_inready returns, with the correct product.
- **Flush coinciding with m_outvalid.**
  - Required: result discarded, m_flush=0, state IDLE the next cycle.
  - Also: a non-owner flush during BUSY leaves the owner's result delivered.
- **Response backpressure.**
  - Stimulus: rsp_ready[0]=0 with rsp_valid[0] set, port 0 requests again, port 1 idle.
  - Required: req_ready[0]=0 and no issue; after rsp_ready[0]=1 the request is accepted the next cycle. Buffer contents stay stable while blocked.
- **Reset mid-BUSY.**
  - Stimulus: rst low for 2 cycles mid-BUSY.
  - Required: all outputs 0 and state IDLE immediately; no stale rsp_valid after release; next op completes correctly.
